// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, state
// encoding and the sign-fixup helper.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [1:0] MD_GRP    = 2'b10;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_e;

  function automatic logic [2*XLEN-1:0] neg_if(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on {hi, lo}: radix-2 shift-add (multiply) or
// restoring shift-subtract (divide). Zero latency, no flow control.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic            div_mode_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {hi_i, lo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    hi_o   = sum[XLEN:1];
    lo_o   = {sum[0], lo_i[XLEN-1:1]};
    if (div_mode_i) begin
      // A clear borrow bit means the divisor fit: keep the difference, quotient bit 1.
      hi_o = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: 32-cycle mul/div, special-case div in 1 cycle.
// Stalls the pipeline with busy; starts while busy are dropped, kill aborts.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e       state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d;

  logic [XLEN-1:0]   step_hi, step_lo, mag_a, mag_b;
  logic [2*XLEN-1:0] prod;
  logic              sa, sb, div_zero, div_ovf;

  muldiv_step u_step (
    .div_mode_i (state_q == ST_DIV),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .opnd_i     (opnd_q),
    .hi_o       (step_hi),
    .lo_o       (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    spec_d   = spec_q;
    result_d = result_q;

    sa = alu_a[XLEN-1] && (alu_op[2:0] != MD_MULHU) && (alu_op[2:0] != MD_DIVU)
                       && (alu_op[2:0] != MD_REMU);
    sb = alu_b[XLEN-1] && ((alu_op[2:0] == MD_MUL) || (alu_op[2:0] == MD_MULH)
                       ||  (alu_op[2:0] == MD_DIV) || (alu_op[2:0] == MD_REM));
    mag_a    = XLEN'(neg_if({{XLEN{1'b0}}, alu_a}, sa));
    mag_b    = XLEN'(neg_if({{XLEN{1'b0}}, alu_b}, sb));
    div_zero = (alu_b == '0);
    div_ovf  = ((alu_op[2:0] == MD_DIV) || (alu_op[2:0] == MD_REM))
               && (alu_a == 32'h8000_0000) && (alu_b == 32'hFFFF_FFFF);
    prod     = neg_if({step_hi, step_lo}, neg_q);

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (start && (alu_op[4:3] == MD_GRP)) begin
            op_d   = alu_op[2:0];
            neg_d  = sa ^ sb;
            rneg_d = sa;
            cnt_d  = '0;
            hi_d   = '0;
            spec_d = 1'b0;
            if (!alu_op[2]) begin
              state_d = ST_MUL;
              lo_d    = mag_b;
              opnd_d  = mag_a;
            end else begin
              state_d = ST_DIV;
              lo_d    = mag_a;
              opnd_d  = mag_b;
              // Special cases park their final answer in lo and skip iteration.
              if (div_zero) begin
                spec_d = 1'b1;
                lo_d   = alu_op[1] ? alu_a : '1;
              end else if (div_ovf) begin
                spec_d = 1'b1;
                lo_d   = alu_op[1] ? '0 : 32'h8000_0000;
              end
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (spec_q) begin
            result_d = lo_q;
            state_d  = ST_DONE;
          end else begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER - 1)) begin
              state_d = ST_DONE;
              case (op_q)
                MD_MUL:                       result_d = prod[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:              result_d = XLEN'(neg_if({{XLEN{1'b0}}, step_lo}, neg_q));
                default:                      result_d = XLEN'(neg_if({{XLEN{1'b0}}, step_hi}, rneg_q));
              endcase
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed results,
// latency, busy/done timing, kill, reset and back-to-back behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, bc;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    alu_op = {MD_GRP, op};
    alu_a  = a;
    alu_b  = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits for done; k0 is the index of the current negedge after the accept edge.
  task automatic wait_done(input string tag, input int k0, output int l, output int nb);
    int k = k0;
    nb = 0;
    while (!done && k < 200) begin
      if (busy) nb++;
      @(negedge clk);
      k++;
    end
    if (!done) chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    else       chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    l = k - 1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int l, nb;
    issue(op, a, b);
    wait_done(tag, 1, l, nb);
    chk(tag, result, exp);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_busy_cycles"}, nb, exp_lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    alu_op = '0; alu_a = '0; alu_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul",    MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
    run_op("mulh",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32);
    run_op("div",    MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
    run_op("rem",    MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
    run_op("divu",   MD_DIVU,   32'd100,       32'd7,         32'd14,        32);
    run_op("remu",   MD_REMU,   32'd100,       32'd7,         32'd2,         32);
    run_op("div0",   MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem0",   MD_REM,    32'd5,         32'd0,         32'd5,         1);
    run_op("divovf", MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Non-M op is ignored.
    start = 1'b1; alu_op = 5'b00000; alu_a = 32'd3; alu_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("non_m_busy", {31'd0, busy}, 32'd0);

    // Start while busy is ignored; original MUL completes on schedule.
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (3) @(negedge clk);
    start = 1'b1; alu_op = {MD_GRP, MD_DIVU}; alu_a = 32'd100; alu_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 5, lat, bc);
    chk("busy_start_res", result, 32'hFFFF_FFEB);
    chk("busy_start_lat", lat, 32);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: start in the DONE cycle.
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done("b2b_a", 1, lat, bc);
    chk("b2b_a_res", result, 32'hFFFF_FFEB);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done("b2b_b", 1, lat, bc);
    chk("b2b_b_res", result, 32'd14);
    chk("b2b_b_lat", lat, 32);
    @(negedge clk);

    // Kill during iteration 10 of a MUL, with a start in the same cycle.
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (9) @(negedge clk);
    kill = 1'b1; start = 1'b1; alu_op = {MD_GRP, MD_DIVU}; alu_a = 32'd8; alu_b = 32'd2;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done}, 32'd0);
    chk("kill_result", result, 32'd14);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("kill_no_done", {31'd0, done}, 32'd0);
    end
    run_op("post_kill_divu", MD_DIVU, 32'd9, 32'd3, 32'd3, 32);

    // Asynchronous reset mid-DIV clears outputs without a clock edge.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_done", {31'd0, done}, 32'd0);
    run_op("post_rst_div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit sitting beside the combinational ALU in the execute stage. Decode routes every operation with alu_op[4:3] == 2'b10 (M-extension) here instead of the single-cycle path. The unit stalls the pipeline via busy and returns one 32-bit result per operation after a fixed iteration count. It uses a radix-2 shift-add multiplier and a restoring shift-subtract divider sharing one 64-bit working register.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per mul/div operation; equals XLEN.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted when busy == 0 and alu_op[4:3] == 2'b10
- alu_op  input  5  operation; [2:0]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- alu_a  input  32  rs1 operand, sampled on the accept edge only
- alu_b  input  32  rs2 operand, sampled on the accept edge only
- kill  input  1  pipeline flush; aborts any in-flight operation
- busy  output  1  high in the MUL and DIV states
- done  output  1  one-cycle pulse; result is valid this cycle
- result  output  32  last completed result, held until the next completion

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE or DONE, on an accepted start:
  - Latch the operand magnitudes, the result-sign flag and the op.
  - Clear the counter.
  - Go to MUL (op[2] = 0) or DIV (op[2] = 1).
- DIV special cases bypass iteration and go straight to DONE with the final result loaded:
  - alu_b == 0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> alu_a.
  - DIV/REM with alu_a == 32'h80000000 and alu_b == 32'hFFFFFFFF: DIV -> 32'h80000000, REM -> 0.
- Signedness:
  - MUL and MULH treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
  - DIV and REM treat both as signed.
- Signed operands are converted to magnitude. The product sign is sign(a) XOR sign(b).
- Signed division: quotient sign is sign(a) XOR sign(b); remainder takes the sign of the dividend.
- MUL: one shift-add step per cycle; 64-bit product in {hi, lo}.
- DIV: one restoring step per cycle; quotient in lo, remainder in hi.
- On the final iteration edge:
  - Apply two's-complement sign fixup to the full 64-bit product or to the quotient/remainder.
  - Select the result: MUL -> low 32 bits; MULH/MULHSU/MULHU -> high 32 bits; DIV/DIVU -> quotient; REM/REMU -> remainder.
  - Load result and enter DONE.
- DONE lasts exactly one cycle with done = 1, then returns to IDLE unless a new start is accepted.
- kill has priority over everything:
  - Next state is IDLE, no done pulse, result unchanged.
  - A start in the same cycle as kill is dropped.
- start with alu_op[4:3] != 2'b10 is ignored.
- start while busy is ignored; the operands are not re-sampled.

## Timing
- Reset (asynchronous): state IDLE, busy 0, done 0, result 0, counter 0, working registers 0.
- Accept edge E0.
- Iterative ops: iterations on E1..E32, result loaded on E32; done = 1 during the cycle after E32, i.e. 32 cycles after E0.
- Special-case DIV: result loaded on E1; done = 1 in the cycle after E1.
- busy:
  - Rises the cycle after E0 and falls in the same cycle that done rises.
  - Is never high together with done.
- Back-to-back: a start presented in the DONE cycle is accepted, giving a throughput of one operation per 33 cycles.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge.
- Deasserting reset yields IDLE; no partial result is ever reported.
- result changes only on the edge that enters DONE.

## Structure
- Shared package muldiv_pkg holds:
  - the op codes for alu_op[2:0] (MD_MUL .. MD_REMU) and the M-extension group code 2'b10;
  - the state encoding;
  - a negate-if function used for sign fixup.
- Sub-module muldiv_step: one combinational iteration (shift-add or shift-subtract selected by mode) on {hi, lo} and the divisor.
- The counter, state machine and sign logic stay in muldiv_unit.

## Test plan
- MUL a = 7, b = -3 (32'hFFFFFFFD) -> result 32'hFFFFFFEB; done exactly 32 cycles after accept; busy high for those 32 cycles.
- MULH a = 32'h80000000, b = 32'h80000000 -> 32'h40000000. MULHU 32'hFFFFFFFF × 32'hFFFFFFFF -> 32'hFFFFFFFE. MULHSU a = -1, b = 2 -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV by zero (a = 5, b = 0) -> 32'hFFFFFFFF with done 1 cycle after accept; REM 5/0 -> 5. DIV 32'h80000000 / -1 -> 32'h80000000; REM of the same -> 0.
- kill at iteration 10 of a MUL -> IDLE next cycle, no done pulse, result keeps its prior value; an immediately following DIVU 9/3 -> 3.
- Reset asserted mid-DIV -> busy, done and result all 0 without a clock edge. Also: a start during busy is ignored, and a start in the DONE cycle is accepted with correct results for both operations.
